// File: rtl/swc_egress_cell_rx.sv
// Egress cell reassembler: buffers 4-beat cells, strips header, emits frames.
// Optional EGR_STATS_EN adds saturating frame/byte/error counters.
module swc_egress_cell_rx #(
   parameter int DEPTH_CELLS   = 8,
   parameter int BP_FREE_CELLS = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cell_wr,
   input  logic [127:0] cell_din,
   input  logic         cell_first,
   input  logic         cell_last,
   output logic         cell_bp,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   output logic         m_sop,
   output logic         m_eop,
   output logic [4:0]   m_bytes,
   output logic         m_err,
   output logic         ovf_sticky,
   output logic [15:0]  stat_frames,
   output logic [31:0]  stat_bytes,
   output logic [15:0]  stat_errs
);

   localparam int NB = DEPTH_CELLS * 4;
   localparam int AW = $clog2(NB);

   typedef struct packed {
      logic         first;
      logic         last;
      logic         i0;
      logic         i3;
      logic [127:0] data;
   } beat_t;

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISCARD} st_t;

   beat_t        mem [NB];
   beat_t        head;
   logic [AW:0]  wr_ptr, rd_ptr, count, cnt_nxt;
   logic [AW+1:0] free_nxt;
   logic [1:0]   beat_idx;
   logic         full, empty, push, pop, bp_nxt;
   logic         hdr_mark, end_mark, out_free, load;

   st_t          st, st_n;
   logic [11:0]  rem, rem_n;
   logic [4:0]   take;
   logic         sop_pend, sop_n, err_pend, errp_n;
   logic [127:0] last_data;

   logic [127:0] o_data;
   logic         o_sop, o_eop, o_err;
   logic [4:0]   o_bytes;

   assign count    = wr_ptr - rd_ptr;
   assign full     = count == (AW+1)'(NB);
   assign empty    = count == '0;
   assign head     = mem[rd_ptr[AW-1:0]];
   assign hdr_mark = head.first && head.i0;
   assign end_mark = head.last && head.i3;
   assign out_free = !m_valid || m_ready;
   assign push     = cell_wr && (!full || pop);
   assign cnt_nxt  = count + (AW+1)'(push) - (AW+1)'(pop);
   assign free_nxt = (AW+2)'(NB) - {1'b0, cnt_nxt};
   assign bp_nxt   = (free_nxt >> 2) <= (AW+2)'(BP_FREE_CELLS);
   assign take     = (rem > 12'd16) ? 5'd16 : rem[4:0];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= {cell_first, cell_last,
                                 beat_idx == 2'd0, beat_idx == 2'd3,
                                 cell_din};
   end

   always_comb begin
      st_n    = st;
      rem_n   = rem;
      sop_n   = sop_pend;
      errp_n  = err_pend;
      pop     = 1'b0;
      load    = 1'b0;
      o_data  = head.data;
      o_sop   = 1'b0;
      o_eop   = 1'b0;
      o_err   = 1'b0;
      o_bytes = 5'd16;
      unique case (st)
         IDLE: begin
            if (!empty) begin
               if (hdr_mark) st_n = HDR;
               else          pop  = 1'b1;
            end
         end
         HDR: begin
            if (!empty) begin
               pop = 1'b1;
               if (head.data[11:0] == 12'd0) begin
                  errp_n = 1'b1;
                  st_n   = DISCARD;
               end else begin
                  rem_n = head.data[11:0];
                  sop_n = 1'b1;
                  st_n  = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (!empty && out_free) begin
               load  = 1'b1;
               o_sop = sop_pend;
               sop_n = 1'b0;
               if (hdr_mark) begin
                  // next frame began early: close this one with a copy
                  o_data = last_data;
                  o_eop  = 1'b1;
                  o_err  = 1'b1;
                  st_n   = HDR;
               end else begin
                  pop     = 1'b1;
                  o_bytes = take;
                  rem_n   = rem - {7'd0, take};
                  if (rem <= 12'd16) begin
                     o_eop = 1'b1;
                     st_n  = end_mark ? IDLE : DISCARD;
                  end else if (end_mark) begin
                     o_eop = 1'b1;
                     o_err = 1'b1;
                     st_n  = IDLE;
                  end
               end
            end
         end
         DISCARD: begin
            if (!empty) begin
               if (hdr_mark || end_mark) begin
                  if (!err_pend || out_free) begin
                     pop  = end_mark;
                     st_n = end_mark ? IDLE : HDR;
                     if (err_pend) begin
                        load    = 1'b1;
                        errp_n  = 1'b0;
                        o_data  = '0;
                        o_sop   = 1'b1;
                        o_eop   = 1'b1;
                        o_err   = 1'b1;
                        o_bytes = 5'd1;
                     end
                  end
               end else begin
                  pop = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         beat_idx   <= '0;
         ovf_sticky <= 1'b0;
         cell_bp    <= 1'b0;
         st         <= IDLE;
         rem        <= '0;
         sop_pend   <= 1'b0;
         err_pend   <= 1'b0;
         last_data  <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_sop      <= 1'b0;
         m_eop      <= 1'b0;
         m_bytes    <= '0;
         m_err      <= 1'b0;
      end else begin
         beat_idx <= beat_idx + {1'b0, cell_wr};
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         if (cell_wr && !push) ovf_sticky <= 1'b1;
         cell_bp  <= bp_nxt;
         st       <= st_n;
         rem      <= rem_n;
         sop_pend <= sop_n;
         err_pend <= errp_n;
         if (load) last_data <= o_data;
         if (out_free) begin
            m_valid <= load;
            if (load) begin
               m_data  <= o_data;
               m_sop   <= o_sop;
               m_eop   <= o_eop;
               m_bytes <= o_bytes;
               m_err   <= o_err;
            end
         end
      end
   end

`ifdef EGR_STATS_EN
   logic        hs;
   logic [32:0] bsum;
   assign hs   = m_valid && m_ready;
   assign bsum = {1'b0, stat_bytes} + 33'(m_bytes);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_frames <= '0;
         stat_bytes  <= '0;
         stat_errs   <= '0;
      end else if (hs) begin
         stat_bytes <= bsum[32] ? '1 : bsum[31:0];
         if (m_eop && !m_err && stat_frames != '1)
            stat_frames <= stat_frames + 16'd1;
         if (m_eop && m_err && stat_errs != '1)
            stat_errs <= stat_errs + 16'd1;
      end
   end
`else
   assign stat_frames = '0;
   assign stat_bytes  = '0;
   assign stat_errs   = '0;
`endif

endmodule
